operand_b_skid_sel: RTL

Parametrised successor to the single-cycle ALU operand-B select, intended for the pipelined core.
- Selects operand B from four candidates: register data, immediate, the constant 4, or one of NUM_FWD forwarding sources.
- Registers the result into a 2-entry skid buffer with a valid/ready handshake toward the EX stage.
- Supports flush and reports a sticky error flag for illegal selects.
- Sits between decode (ID) and the ALU input in EX.

---
 rtl/core_pkg.sv | 20 ++
 rtl/operand_b_mux.sv | 47 ++++
 rtl/operand_b_skid_sel.sv | 117 +++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: operand-B select encoding, skid buffer occupancy
// states and the constant-four operand.
package core_pkg;

    typedef enum logic [1:0] {
        SELB_RS2  = 2'b00,
        SELB_IMM  = 2'b01,
        SELB_FOUR = 2'b10,
        SELB_RSVD = 2'b11
    } selb_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_e;

    localparam logic [31:0] FOUR = 32'd4;

endpackage

// File: rtl/operand_b_mux.sv
// Combinational operand-B select with forwarding override and illegal-select flag.
module operand_b_mux
    import core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int FW      = $clog2(NUM_FWD + 1)
) (
    input  logic [1:0]              sel_B,
    input  logic [FW-1:0]           fwd_sel,
    input  logic [XLEN-1:0]         rdata2,
    input  logic [XLEN-1:0]         ImmExtD,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]         value,
    output logic                    illegal
);

    localparam logic [FW-1:0] NUM_FWD_W = FW'(NUM_FWD);

    // Select function; forwarding only overrides the register operand
    always_comb begin
        value   = '0;
        illegal = 1'b0;
        case (selb_e'(sel_B))
            SELB_RS2: begin
                value = rdata2;
                for (int k = 1; k <= NUM_FWD; k++) begin
                    if (fwd_sel == FW'(k)) begin
                        value = fwd_data[k*XLEN-1 -: XLEN];
                    end else begin
                        value = value;
                    end
                end
                if (fwd_sel > NUM_FWD_W) begin
                    illegal = 1'b1;
                end else begin
                    illegal = 1'b0;
                end
            end
            SELB_IMM:  value = ImmExtD;
            SELB_FOUR: value = XLEN'(FOUR);
            SELB_RSVD: illegal = 1'b1;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/operand_b_skid_sel.sv
// Operand-B select registered into a 2-entry skid buffer with valid/ready
// handshake toward EX, flush, and a sticky illegal-select flag.
module operand_b_skid_sel
    import core_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    localparam int FW     = $clog2(NUM_FWD + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              sel_B,
    input  logic [FW-1:0]           fwd_sel,
    input  logic [XLEN-1:0]         rdata2,
    input  logic [XLEN-1:0]         ImmExtD,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [XLEN-1:0]         SrcB,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    fwd_err
);

    buf_state_e      state_r, state_s;
    logic [XLEN-1:0] head_r, head_s;
    logic [XLEN-1:0] tail_r, tail_s;
    logic            fwd_err_r;
    logic [XLEN-1:0] sel_value_s;
    logic            sel_illegal_s;
    logic            push_s, pop_s;

    operand_b_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .FW(FW)) u_mux (
        .sel_B    (sel_B),
        .fwd_sel  (fwd_sel),
        .rdata2   (rdata2),
        .ImmExtD  (ImmExtD),
        .fwd_data (fwd_data),
        .value    (sel_value_s),
        .illegal  (sel_illegal_s)
    );

    assign in_ready  = (state_r != BUF_TWO);
    assign out_valid = (state_r != BUF_EMPTY);
    assign push_s    = in_valid & in_ready & ~flush;
    assign pop_s     = out_valid & out_ready;
    assign SrcB      = head_r;
    assign fwd_err   = fwd_err_r;

    // Next occupancy and entry contents; vacated slots are zeroed so SrcB reads 0 when empty
    always_comb begin
        state_s = state_r;
        head_s  = head_r;
        tail_s  = tail_r;
        case (state_r)
            BUF_EMPTY: begin
                if (push_s) begin
                    state_s = BUF_ONE;
                    head_s  = sel_value_s;
                end else begin
                    state_s = BUF_EMPTY;
                end
            end
            BUF_ONE: begin
                if (push_s && pop_s) begin
                    head_s = sel_value_s;
                end else if (push_s) begin
                    state_s = BUF_TWO;
                    tail_s  = sel_value_s;
                end else if (pop_s) begin
                    state_s = BUF_EMPTY;
                    head_s  = '0;
                end else begin
                    state_s = BUF_ONE;
                end
            end
            BUF_TWO: begin
                if (pop_s) begin
                    state_s = BUF_ONE;
                    head_s  = tail_r;
                    tail_s  = '0;
                end else begin
                    state_s = BUF_TWO;
                end
            end
            default: begin
                state_s = BUF_EMPTY;
                head_s  = '0;
                tail_s  = '0;
            end
        endcase
        if (flush) begin
            state_s = BUF_EMPTY;
            head_s  = '0;
            tail_s  = '0;
        end else begin
            state_s = state_s;
        end
    end

    // Buffer state, entries and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= BUF_EMPTY;
            head_r    <= '0;
            tail_r    <= '0;
            fwd_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            head_r    <= head_s;
            tail_r    <= tail_s;
            fwd_err_r <= fwd_err_r | (push_s & sel_illegal_s);
        end
    end

endmodule
